// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32IM definitions for the core.
//   - Base opcode constants.
//   - ALU operation, writeback-select and immediate-format enums.
//   - ctrl_t: the decoded control bundle carried down the pipeline.
//   - gen_imm(): sign-extended immediate extraction.
//   - alu_base_op(): funct3 -> ALU op for the OP / OP-IMM groups.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // ALU_ADD is encoding 0, so an all-zero bubble bundle decodes as a harmless add.
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    // alu_src_a: 0 = rs1, 1 = pc.  alu_src_b: 0 = rs2, 1 = imm.
    // mem_funct3 holds funct3 for loads/stores (size/sign) and for branches
    // (compare type); it is 0 for everything else.
    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
        logic       reg_write;
        wb_sel_e    wb_sel;
        logic       branch;
        logic       jump;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt selects SUB over ADD and SRA over SRL (inst[30]).
    function automatic alu_op_e alu_base_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/p_reg.sv
// p_reg: plain pipeline register, synchronous active-high reset to 0.
//   clk, rst   clock / sync reset
//   data_d     next value
//   data_q     registered value
module p_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_d,
    output logic [W-1:0] data_q
);

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

endmodule

// File: rtl/rv32i_reg_file.sv
// rv32i_reg_file: architectural register file.
//   2 asynchronous read ports, 1 synchronous write port, x0 hard-wired to 0.
//   A read of the register being written this cycle returns the write data
//   (write-through), so WB and ID may overlap without a hazard.
//   clk, rst                      clock / sync reset (clears every entry)
//   i_rs1, i_rs2                  read addresses
//   o_rs1_data, o_rs2_data        read data
//   i_wr_en, i_wr_addr, i_wr_data write port
module rv32i_reg_file #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic [WIDTH-1:0]      o_rs1_data,
    output logic [WIDTH-1:0]      o_rs2_data,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data
);

    localparam int NREGS = 1 << REG_ADDR_W;

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];

    always_comb begin
        rf_d = rf_q;
        if (i_wr_en && i_wr_addr != '0) rf_d[i_wr_addr] = i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) rf_q <= '{default: '0};
        else     rf_q <= rf_d;
    end

    // Address 0 short-circuits first, so the bypass never fires for x0.
    assign o_rs1_data = (i_rs1 == '0) ? '0 :
                        (i_wr_en && i_wr_addr == i_rs1) ? i_wr_data : rf_q[i_rs1];
    assign o_rs2_data = (i_rs2 == '0) ? '0 :
                        (i_wr_en && i_wr_addr == i_rs2) ? i_wr_data : rf_q[i_rs2];

endmodule

// File: rtl/p_id_ex_stage.sv
// p_id_ex_stage: decode stage and ID/EX pipeline register of the RV32IM core.
//   Inputs : i_inst / i_pc / i_pc_plus_4 from IF/ID, i_flush from EX,
//            i_wb_en / i_wb_rd / i_wb_data register-file write from WB.
//   Outputs: o_stall (combinational load-use stall for PC and IF/ID),
//            registered o_valid, o_ctrl, o_pc, o_pc_plus_4, o_rs1_data,
//            o_rs2_data, o_imm, o_rs1, o_rs2, o_rd.
//   Bubbles (flush, load-use, unsupported opcode) drive every ID/EX field to 0.
//   For valid instructions, source indices/data of unused operands and the
//   destination index of non-writing instructions are also 0, so EX forwarding
//   never matches on bits that are really immediate fields.
module p_id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_inst,
    input  logic [WIDTH-1:0]      i_pc,
    input  logic [WIDTH-1:0]      i_pc_plus_4,
    input  logic                  i_flush,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [WIDTH-1:0]      i_wb_data,
    output logic                  o_stall,
    output logic                  o_valid,
    output ctrl_t                 o_ctrl,
    output logic [WIDTH-1:0]      o_pc,
    output logic [WIDTH-1:0]      o_pc_plus_4,
    output logic [WIDTH-1:0]      o_rs1_data,
    output logic [WIDTH-1:0]      o_rs2_data,
    output logic [WIDTH-1:0]      o_imm,
    output logic [REG_ADDR_W-1:0] o_rs1,
    output logic [REG_ADDR_W-1:0] o_rs2,
    output logic [REG_ADDR_W-1:0] o_rd
);

    localparam int IDEX_W = 1 + $bits(ctrl_t) + 5 * WIDTH + 3 * REG_ADDR_W;

    // ---------------- instruction fields ----------------
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;

    assign opcode = i_inst[6:0];
    assign rd     = i_inst[11:7];
    assign funct3 = i_inst[14:12];
    assign rs1    = i_inst[19:15];
    assign rs2    = i_inst[24:20];
    assign funct7 = i_inst[31:25];

    // ---------------- register file ----------------
    logic [WIDTH-1:0] rf_rs1_data, rf_rs2_data;

    rv32i_reg_file #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .o_rs1_data (rf_rs1_data),
        .o_rs2_data (rf_rs2_data),
        .i_wr_en    (i_wb_en),
        .i_wr_addr  (i_wb_rd),
        .i_wr_data  (i_wb_data)
    );

    // ---------------- decode ----------------
    ctrl_t    dec_ctrl;
    logic     dec_legal;
    imm_fmt_e imm_fmt;
    logic     rs1_used, rs2_used;

    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        imm_fmt   = IMM_NONE;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        case (opcode)
            OPC_OP: begin
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                if (funct7 == FUNCT7_MULDIV)
                    dec_ctrl.alu_op = alu_op_e'(ALU_MUL + funct3);
                else
                    dec_ctrl.alu_op = alu_base_op(funct3, funct7[5]);
            end
            OPC_OP_IMM: begin
                imm_fmt            = IMM_I;
                rs1_used           = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                // inst[30] only means SRAI; for ADDI it is an immediate bit.
                dec_ctrl.alu_op    = alu_base_op(funct3, (funct3 == 3'b101) && i_inst[30]);
            end
            OPC_LOAD: begin
                imm_fmt             = IMM_I;
                rs1_used            = 1'b1;
                dec_ctrl.alu_src_b  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_funct3 = funct3;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.wb_sel     = WB_MEM;
            end
            OPC_STORE: begin
                imm_fmt             = IMM_S;
                rs1_used            = 1'b1;
                rs2_used            = 1'b1;
                dec_ctrl.alu_src_b  = 1'b1;
                dec_ctrl.mem_write  = 1'b1;
                dec_ctrl.mem_funct3 = funct3;
            end
            OPC_BRANCH: begin
                imm_fmt             = IMM_B;
                rs1_used            = 1'b1;
                rs2_used            = 1'b1;
                dec_ctrl.alu_op     = ALU_SUB;
                dec_ctrl.mem_funct3 = funct3;
                dec_ctrl.branch     = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt            = IMM_J;
                dec_ctrl.alu_src_a = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_PC4;
                dec_ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                imm_fmt            = IMM_I;
                rs1_used           = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_PC4;
                dec_ctrl.jump      = 1'b1;
            end
            OPC_LUI: begin
                imm_fmt            = IMM_U;
                dec_ctrl.alu_op    = ALU_PASS_B;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_fmt            = IMM_U;
                dec_ctrl.alu_src_a = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // ---------------- load-use hazard ----------------
    // The load sitting in ID/EX has no data until MEM, too late to forward into
    // EX for the instruction now in ID: insert one bubble and hold IF/ID.
    logic load_use;

    assign load_use = o_valid && o_ctrl.mem_read && (o_rd != '0) &&
                      ((rs1_used && o_rd == rs1) || (rs2_used && o_rd == rs2));

    // A flush discards the dependent instruction anyway, so no stall is needed.
    assign o_stall = load_use && !i_flush;

    // ---------------- ID/EX next state ----------------
    logic                  valid_d;
    ctrl_t                 ctrl_d;
    logic [WIDTH-1:0]      pc_d, pc_plus_4_d, rs1_data_d, rs2_data_d, imm_d;
    logic [REG_ADDR_W-1:0] rs1_idx_d, rs2_idx_d, rd_idx_d;

    always_comb begin
        valid_d     = 1'b0;
        ctrl_d      = '0;
        pc_d        = '0;
        pc_plus_4_d = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        rs1_idx_d   = '0;
        rs2_idx_d   = '0;
        rd_idx_d    = '0;
        if (!i_flush && !load_use && dec_legal) begin
            valid_d     = 1'b1;
            ctrl_d      = dec_ctrl;
            pc_d        = i_pc;
            pc_plus_4_d = i_pc_plus_4;
            imm_d       = gen_imm(i_inst, imm_fmt);
            rs1_idx_d   = rs1_used ? rs1 : '0;
            rs2_idx_d   = rs2_used ? rs2 : '0;
            rs1_data_d  = rs1_used ? rf_rs1_data : '0;
            rs2_data_d  = rs2_used ? rf_rs2_data : '0;
            rd_idx_d    = dec_ctrl.reg_write ? rd : '0;
        end
    end

    p_reg #(
        .W (IDEX_W)
    ) u_id_ex_reg (
        .clk    (clk),
        .rst    (rst),
        .data_d ({valid_d, ctrl_d, pc_d, pc_plus_4_d, rs1_data_d, rs2_data_d, imm_d,
                  rs1_idx_d, rs2_idx_d, rd_idx_d}),
        .data_q ({o_valid, o_ctrl, o_pc, o_pc_plus_4, o_rs1_data, o_rs2_data, o_imm,
                  o_rs1, o_rs2, o_rd})
    );

endmodule

// File: tb/tb_p_id_ex_stage.sv
// tb_p_id_ex_stage: self-checking bench for the ID stage / ID/EX register.
module tb_p_id_ex_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_inst, i_pc, i_pc_plus_4, i_wb_data;
    logic        i_flush, i_wb_en;
    logic [4:0]  i_wb_rd;
    logic        o_stall, o_valid;
    ctrl_t       o_ctrl;
    logic [31:0] o_pc, o_pc_plus_4, o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;

    p_id_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .i_inst(i_inst), .i_pc(i_pc), .i_pc_plus_4(i_pc_plus_4),
        .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_stall(o_stall), .o_valid(o_valid), .o_ctrl(o_ctrl), .o_pc(o_pc),
        .o_pc_plus_4(o_pc_plus_4), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] X1_VAL = 32'hDEADBEEF;
    localparam logic [31:0] X2_VAL = 32'h00000022;

    function automatic ctrl_t mk(alu_op_e op, logic sa, logic sbm, logic mr, logic mw,
                                 logic [2:0] f3, logic rw, wb_sel_e wb, logic br, logic j);
        ctrl_t c;
        c.alu_op = op; c.alu_src_a = sa; c.alu_src_b = sbm; c.mem_read = mr;
        c.mem_write = mw; c.mem_funct3 = f3; c.reg_write = rw; c.wb_sel = wb;
        c.branch = br; c.jump = j;
        return c;
    endfunction

    function automatic exp_t mke(ctrl_t c, logic [31:0] pc, logic [31:0] imm, logic [4:0] rd,
                                 logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.valid = 1'b1; e.ctrl = c; e.pc = pc; e.imm = imm; e.rd = rd; e.a = a; e.b = b;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        i_inst      = inst;
        i_pc        = pc;
        i_pc_plus_4 = pc + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0; i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        drive(32'h0, 32'h0);
        tick();
        rst = 1'b0;
        // put a value in x5, then reset again: it must be gone afterwards
        i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h00001234;
        drive(32'h00500093, 32'h40);
        tick();
        i_wb_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({o_valid, o_ctrl} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got valid=%0d ctrl=%h, want 0/0", o_valid, o_ctrl);
        end
        n_tests++;
        if ({o_pc, o_pc_plus_4, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd} !== '0) begin
            n_fail++; $display("FAIL reset_data: got pc=%h imm=%h rd=%0d a=%h b=%h, want all 0",
                               o_pc, o_imm, o_rd, o_rs1_data, o_rs2_data);
        end
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", o_stall);
        end
        drive(32'h00028333, 32'h80);  // add x6,x5,x0
        tick();
        n_tests++;
        if ({o_valid, o_rd, o_rs1, o_rs1_data} !== {1'b1, 5'd6, 5'd5, 32'h0}) begin
            n_fail++; $display("FAIL reset_rf_x5: got valid=%0d rd=%0d rs1=%0d data=%h want 1/6/5/0",
                               o_valid, o_rd, o_rs1, o_rs1_data);
        end
    endtask

    task automatic test_addi();
        exp_t e;
        drive(32'h00500093, 32'h100);  // addi x1,x0,5
        sb.push_back(mke(mk(ALU_ADD, 0, 1, 0, 0, 3'd0, 1, WB_ALU, 0, 0),
                         32'h100, 32'd5, 5'd1, 32'h0, 32'h0));
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({o_valid, o_ctrl, o_pc, o_pc_plus_4, o_imm, o_rd, o_rs1_data, o_rs2_data} !==
            {e.valid, e.ctrl, e.pc, e.pc + 32'd4, e.imm, e.rd, e.a, e.b}) begin
            n_fail++;
            $display("FAIL addi: got v=%0d ctrl=%h pc=%h imm=%h rd=%0d a=%h b=%h want v=%0d ctrl=%h pc=%h imm=%h rd=%0d a=%h b=%h",
                     o_valid, o_ctrl, o_pc, o_imm, o_rd, o_rs1_data, o_rs2_data,
                     e.valid, e.ctrl, e.pc, e.imm, e.rd, e.a, e.b);
        end
    endtask

    task automatic test_bypass();
        // write x1 while add x2,x1,x1 reads it in the same cycle
        i_wb_en = 1'b1; i_wb_rd = 5'd1; i_wb_data = X1_VAL;
        drive(32'h00108133, 32'h200);
        tick();
        n_tests++;
        if ({o_rs1_data, o_rs2_data} !== {X1_VAL, X1_VAL}) begin
            n_fail++; $display("FAIL bypass: got a=%h b=%h want %h", o_rs1_data, o_rs2_data, X1_VAL);
        end
        // x1 now from storage; write x2 meanwhile
        i_wb_rd = 5'd2; i_wb_data = X2_VAL;
        tick();
        n_tests++;
        if (o_rs1_data !== X1_VAL) begin
            n_fail++; $display("FAIL rf_store: got %h want %h", o_rs1_data, X1_VAL);
        end
        // write to x0 must neither bypass nor stick
        i_wb_rd = 5'd0; i_wb_data = 32'hFFFFFFFF;
        drive(32'h00200133, 32'h204);  // add x2,x0,x2
        tick();
        n_tests++;
        if ({o_rs1_data, o_rs2_data} !== {32'h0, X2_VAL}) begin
            n_fail++; $display("FAIL x0_bypass: got a=%h b=%h want 0/%h", o_rs1_data, o_rs2_data, X2_VAL);
        end
        i_wb_en = 1'b0;
        tick();
        n_tests++;
        if (o_rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_write: got %h want 0", o_rs1_data);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] first [5];
        logic [31:0] second [5];
        logic        stall [5];
        first[0] = 32'h0000A183; second[0] = 32'h00318233; stall[0] = 1'b1; // lw x3 / add x4,x3,x3
        first[1] = 32'h0000A183; second[1] = 32'h000182B7; stall[1] = 1'b0; // lw x3 / lui (field=3)
        first[2] = 32'h0000A183; second[2] = 32'h00302023; stall[2] = 1'b1; // lw x3 / sw x3,0(x0)
        first[3] = 32'h0000A003; second[3] = 32'h00000233; stall[3] = 1'b0; // lw x0 / add x4,x0,x0
        first[4] = 32'h00100193; second[4] = 32'h00318233; stall[4] = 1'b0; // addi x3 / add x4,x3,x3
        for (int k = 0; k < 5; k++) begin
            drive(first[k], 32'h300 + 32'(k * 16));
            tick();
            drive(second[k], 32'h304 + 32'(k * 16));
            #1;
            n_tests++;
            if (o_stall !== stall[k]) begin
                n_fail++; $display("FAIL load_use_stall[%0d]: got %b want %b", k, o_stall, stall[k]);
            end
            tick();
            if (stall[k]) begin
                n_tests++;
                if ({o_valid, o_ctrl, o_stall} !== '0) begin
                    n_fail++; $display("FAIL load_use_bubble[%0d]: got valid=%0d ctrl=%h stall=%b want 0/0/0",
                                       k, o_valid, o_ctrl, o_stall);
                end
                tick();
            end
            n_tests++;
            if ({o_valid, o_pc} !== {1'b1, 32'h304 + 32'(k * 16)}) begin
                n_fail++; $display("FAIL load_use_issue[%0d]: got valid=%0d pc=%h want 1/%h",
                                   k, o_valid, o_pc, 32'h304 + 32'(k * 16));
            end
        end
    endtask

    task automatic test_flush();
        drive(32'h0000A183, 32'h400);  // lw x3
        tick();
        drive(32'h00318233, 32'h404);  // dependent add, but EX redirects
        i_flush = 1'b1;
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b want 0", o_stall);
        end
        tick();
        n_tests++;
        if ({o_valid, o_ctrl} !== '0) begin
            n_fail++; $display("FAIL flush_bubble: got valid=%0d ctrl=%h want 0/0", o_valid, o_ctrl);
        end
        drive(32'h00500093, 32'h800);  // legal decode still squashed
        tick();
        n_tests++;
        if ({o_valid, o_ctrl, o_rd} !== '0) begin
            n_fail++; $display("FAIL flush_decode: got valid=%0d ctrl=%h rd=%0d want 0", o_valid, o_ctrl, o_rd);
        end
        i_flush = 1'b0;
        tick();
        n_tests++;
        if ({o_valid, o_rd} !== {1'b1, 5'd1}) begin
            n_fail++; $display("FAIL flush_release: got valid=%0d rd=%0d want 1/1", o_valid, o_rd);
        end
    endtask

    task automatic test_branch_jal();
        drive(32'hFE000CE3, 32'h500);  // beq x0,x0,-8
        tick();
        n_tests++;
        if ({o_valid, o_imm, o_ctrl.branch, o_ctrl.jump, o_ctrl.reg_write} !==
            {1'b1, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL beq: got v=%0d imm=%h br=%b j=%b rw=%b want 1/fffffff8/1/0/0",
                               o_valid, o_imm, o_ctrl.branch, o_ctrl.jump, o_ctrl.reg_write);
        end
        drive(32'h001000EF, 32'h504);  // jal x1,+2048
        tick();
        n_tests++;
        if ({o_valid, o_imm, o_ctrl.wb_sel, o_ctrl.jump, o_rd} !==
            {1'b1, 32'h00000800, WB_PC4, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL jal: got v=%0d imm=%h wb=%0d j=%b rd=%0d want 1/00000800/2/1/1",
                               o_valid, o_imm, o_ctrl.wb_sel, o_ctrl.jump, o_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [7];
        exp_t        exps [7];
        exp_t        e;
        insts[0] = 32'hFFF08493; exps[0] = mke(mk(ALU_ADD, 0, 1, 0, 0, 3'd0, 1, WB_ALU, 0, 0), 32'h600, 32'hFFFFFFFF, 5'd9,  X1_VAL, 32'h0);
        insts[1] = 32'h4030D513; exps[1] = mke(mk(ALU_SRA, 0, 1, 0, 0, 3'd0, 1, WB_ALU, 0, 0), 32'h604, 32'h00000403, 5'd10, X1_VAL, 32'h0);
        insts[2] = 32'h402085B3; exps[2] = mke(mk(ALU_SUB, 0, 0, 0, 0, 3'd0, 1, WB_ALU, 0, 0), 32'h608, 32'h0,        5'd11, X1_VAL, X2_VAL);
        insts[3] = 32'hFE20AE23; exps[3] = mke(mk(ALU_ADD, 0, 1, 0, 1, 3'd2, 0, WB_ALU, 0, 0), 32'h60C, 32'hFFFFFFFC, 5'd0,  X1_VAL, X2_VAL);
        insts[4] = 32'h12345397; exps[4] = mke(mk(ALU_ADD, 1, 1, 0, 0, 3'd0, 1, WB_ALU, 0, 0), 32'h610, 32'h12345000, 5'd7,  32'h0,  32'h0);
        insts[5] = 32'h02208433; exps[5] = mke(mk(ALU_MUL, 0, 0, 0, 0, 3'd0, 1, WB_ALU, 0, 0), 32'h614, 32'h0,        5'd8,  X1_VAL, X2_VAL);
        insts[6] = 32'h008100E7; exps[6] = mke(mk(ALU_ADD, 0, 1, 0, 0, 3'd0, 1, WB_PC4, 0, 1), 32'h618, 32'h00000008, 5'd1,  X2_VAL, 32'h0);
        for (int k = 0; k < 7; k++) begin
            drive(insts[k], exps[k].pc);
            sb.push_back(exps[k]);
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({o_valid, o_ctrl, o_pc, o_imm, o_rd, o_rs1_data, o_rs2_data} !==
                {e.valid, e.ctrl, e.pc, e.imm, e.rd, e.a, e.b}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%0d ctrl=%h pc=%h imm=%h rd=%0d a=%h b=%h want v=%0d ctrl=%h pc=%h imm=%h rd=%0d a=%h b=%h",
                         k, o_valid, o_ctrl, o_pc, o_imm, o_rd, o_rs1_data, o_rs2_data,
                         e.valid, e.ctrl, e.pc, e.imm, e.rd, e.a, e.b);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'h00000000;
        bad[1] = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            drive(bad[k], 32'h700);
            tick();
            n_tests++;
            if ({o_valid, o_ctrl, o_rd, o_imm} !== '0) begin
                n_fail++; $display("FAIL illegal[%0d]: got valid=%0d ctrl=%h rd=%0d imm=%h want 0",
                                   k, o_valid, o_ctrl, o_rd, o_imm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_flush();
        test_branch_jal();
        test_back_to_back();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
